mem_port_ctrl: RTL and testbench
================================

// Module: mem_port_ctrl
// PURPOSE
//  N-channel byte-serial memory controller between the pipeline requesters (IF, MEM, future
//  prefetch/cache ports) and the 8-bit RAM/IO bus.
//  Arbitrates channels, splits 1/2/4-byte accesses into byte cycles, and assembles read words.
//  Holds IO writes while the UART buffer is full. Freezes on rdy low.
// PARAMETERS
//  NCH     2      number of requester channels (1..8); channel 0 = highest fixed priority
//  AW      32     address width of requests and ram_addr_o
//  IO_SEL  2'b11  value of addr[17:16] that marks an IO access
// PORTS
//  clk               in   1       system clock
//  rst               in   1       synchronous, active-low reset
//  rdy               in   1       pause: low freezes all state
//  ram_data_i        in   8       RAM read byte (for address presented previous cycle)
//  ram_data_o        out  8       RAM write byte
//  ram_addr_o        out  AW      RAM byte address
//  ram_wr_o          out  1       1 = write this cycle
//  io_buffer_full_i  in   1       UART buffer full
//  req_valid_i       in   NCH     request pending per channel; held until done or abort
//  req_wr_i          in   NCH     1 = store
//  req_size_i        in   2*NCH   0 = byte, 1 = half, 2/3 = word
//  req_addr_i        in   AW*NCH  byte address, channel c at [c*AW +: AW]
//  req_wdata_i       in   32*NCH  store data, little-endian
//  abort_i           in   NCH     drop the in-flight read of that channel (jump flush)
//  done_o            out  NCH     one-cycle pulse: channel's access complete
//  rdata_o           out  32      read data, zero-extended; valid only in done_o cycle
//  busy_o            out  1       FSM not IDLE
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE, byte counter 0, RR pointer NCH-1. Outputs: ram_* = 0,
//   done_o = 0, rdata_o = 0, busy_o = 0. rst overrides rdy. Reset mid-transaction abandons it.
//  States: IDLE -> READ | WRITE -> IDLE.
//   IDLE: at edge T, grant one valid channel, latch its addr/size/wdata/wr, and go to READ or WRITE.
//  Byte count k: 1/2/4 by size. Bytes are issued at addr, addr+1, ..., addr+k-1. AW-bit add, wraps.
//  READ: byte i address driven in cycle T+1+i (ram_wr_o = 0); byte i captured in cycle T+2+i.
//   done_o[g] and rdata_o are driven in cycle T+k+1, then the FSM returns to IDLE.
//   Next grant no earlier than edge T+k+2.
//  WRITE: byte i driven in cycle T+1+i with ram_wr_o = 1; done_o[g] pulses in cycle T+k; FSM -> IDLE.
//  IO hold: write with addr[17:16]==IO_SEL while io_buffer_full_i = 1 -> ram_wr_o = 0;
//   address and byte are held, no progress; resumes the first cycle full = 0.
//  rdy = 0: every register holds; ram_wr_o forced 0; ram_addr_o holds.
//   On the first cycle rdy returns high, capture uses ram_data_i (still valid because the address was held).
//  abort_i[g] with g granted and state READ: at next edge -> IDLE; no done_o; captured bytes discarded.
//  abort_i on a WRITE, or on a non-granted channel: ignored. A write always completes.
//  A grant drop on valid deassertion is not supported: requesters keep valid high until done or abort.
//  Simultaneous done and new request on the same channel: the new request is seen at the next IDLE edge.
//  Idle bus: ram_addr_o = 0, ram_data_o = 0, ram_wr_o = 0.
// CONFIGURATION
//  MEMCTRL_ROUND_ROBIN_EN defined: grant = first valid channel after the last granted one (rotating).
//  Not defined: fixed priority, lowest index wins; RR pointer register removed.
// STRUCTURE
//  Shared header (consts.v): size encodings, FSM state encodings, IO_SEL default, byte-count table.
//  Sub-module mem_port_arbiter: combinational grant + one-hot output.
//   Its RR pointer is updated on grant; it is only compiled when MEMCTRL_ROUND_ROBIN_EN is defined.
// TESTING
//  Reset: rst=0 two cycles with req_valid=2'b11 -> done_o=0, ram_wr_o=0, busy_o=0, no grant.
//  Word read ch0 addr 0x100, RAM bytes 11,22,33,44 -> addresses 0x100..0x103 on T+1..T+4; done_o[0] at T+5; rdata_o=0x44332211.
//  Half write ch1 addr 0x2FFFF data 0xBEEF -> (0x2FFFF,EF,wr=1), (0x30000,BE,wr=1); done_o[1] at T+2.
//  IO byte write 0x30000 with io_buffer_full_i high for 3 cycles -> ram_wr_o=0 for 3 cycles, then one write; done follows.
//  Both channels valid continuously -> RR: grants alternate 0,1,0,1; no RR: ch0 every time.
//  Word read ch0, abort_i[0] in cycle T+2 -> no done_o[0], IDLE at T+3; rdy low 2 cycles mid-read -> rdata correct, done delayed 2.

Source files
------------

// File: rtl/mem_port_ctrl_pkg.sv
// ============================================================================
// Module : mem_port_ctrl_pkg
// Brief  : Shared encodings for mem_port_ctrl: access sizes, FSM states,
//          IO-window default and the size -> byte-count table.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_port_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: byte_count = 3'd1;
            SZ_HALF: byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Combinational channel grant with one-hot output. Rotating priority
//          when MEMCTRL_ROUND_ROBIN_EN is defined, else lowest index wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_ctrl_pkg::*;
#(
    parameter int NCH = 2
) (
`ifdef MEMCTRL_ROUND_ROBIN_EN
    input  logic           clk,
    input  logic           rst,
    input  logic           grant_en,
`endif
    input  logic [NCH-1:0] valid,
    output logic           any,
    output logic [NCH-1:0] onehot
);

`ifdef MEMCTRL_ROUND_ROBIN_EN
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;

    // Search starts just after the last granted channel; descending loop so
    // the nearest hit is written last.
    always_comb begin
        int c;
        c   = 0;
        any = 1'b0;
        idx = '0;
        for (int off = NCH; off >= 1; off--) begin
            c = (int'(ptr) + off) % NCH;
            if (valid[IW'(c)]) begin
                any = 1'b1;
                idx = IW'(c);
            end
        end
        onehot = any ? (NCH'(1) << idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= IW'(NCH - 1);
        end else if (grant_en) begin
            ptr <= idx;
        end
    end
`else
    always_comb begin
        any    = |valid;
        onehot = valid & ~(valid - NCH'(1));
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_ctrl.sv
// ============================================================================
// Module : mem_port_ctrl
// Brief  : N-channel byte-serial memory controller for an 8-bit RAM/IO bus.
//          Build option: MEMCTRL_ROUND_ROBIN_EN selects rotating arbitration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int         NCH    = 2,
    parameter int         AW     = 32,
    parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        ram_data_i,
    output logic [7:0]        ram_data_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic              ram_wr_o,
    input  logic              io_buffer_full_i,
    input  logic [NCH-1:0]    req_valid_i,
    input  logic [NCH-1:0]    req_wr_i,
    input  logic [2*NCH-1:0]  req_size_i,
    input  logic [AW*NCH-1:0] req_addr_i,
    input  logic [32*NCH-1:0] req_wdata_i,
    input  logic [NCH-1:0]    abort_i,
    output logic [NCH-1:0]    done_o,
    output logic [31:0]       rdata_o,
    output logic              busy_o
);

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [2:0]     cnt;
    logic [NCH-1:0] gmask;
    logic [AW-1:0]  base;
    logic [1:0]     size;
    logic [31:0]    wdata;
    logic [23:0]    rbuf;

    logic           arb_any;
    logic [NCH-1:0] arb_onehot;
    logic [AW-1:0]  sel_addr;
    logic [1:0]     sel_size;
    logic [31:0]    sel_wdata;
    logic           sel_wr;

    logic [2:0]     nbytes;
    logic [AW-1:0]  cur_addr;
    logic           io_hold;
    logic           last_rd;
    logic           last_wr;
    logic           aborted;
    logic [7:0]     wbyte;
    logic [31:0]    rd_word;

`ifdef MEMCTRL_ROUND_ROBIN_EN
    logic grant_en;
    assign grant_en = (state == ST_IDLE) && rdy && arb_any;
`endif

    mem_port_arbiter #(
        .NCH (NCH)
    ) u_arb (
`ifdef MEMCTRL_ROUND_ROBIN_EN
        .clk      (clk),
        .rst      (rst),
        .grant_en (grant_en),
`endif
        .valid    (req_valid_i),
        .any      (arb_any),
        .onehot   (arb_onehot)
    );

    always_comb begin
        sel_addr  = '0;
        sel_size  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            sel_addr  = sel_addr  | (req_addr_i[c*AW +: AW]  & {AW{arb_onehot[c]}});
            sel_size  = sel_size  | (req_size_i[c*2 +: 2]    & {2{arb_onehot[c]}});
            sel_wdata = sel_wdata | (req_wdata_i[c*32 +: 32] & {32{arb_onehot[c]}});
            sel_wr    = sel_wr    | (req_wr_i[c] & arb_onehot[c]);
        end
    end

    assign nbytes   = byte_count(size);
    assign cur_addr = base + AW'(cnt);
    assign io_hold  = (state == ST_WRITE) && (cur_addr[17:16] == IO_SEL) && io_buffer_full_i;
    assign last_rd  = (state == ST_READ)  && (cnt == nbytes);
    assign last_wr  = (state == ST_WRITE) && (cnt == nbytes - 3'd1);
    assign aborted  = (state == ST_READ)  && |(abort_i & gmask);

    always_comb begin
        case (cnt[1:0])
            2'd0:    wbyte = wdata[7:0];
            2'd1:    wbyte = wdata[15:8];
            2'd2:    wbyte = wdata[23:16];
            default: wbyte = wdata[31:24];
        endcase
    end

    // The final byte is still on the bus in the done cycle, so it bypasses rbuf.
    always_comb begin
        case (size)
            SZ_BYTE: rd_word = {24'd0, ram_data_i};
            SZ_HALF: rd_word = {16'd0, ram_data_i, rbuf[7:0]};
            default: rd_word = {ram_data_i, rbuf};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = sel_wr ? ST_WRITE : ST_READ;
            ST_READ:  if (aborted || last_rd) state_nxt = ST_IDLE;
            ST_WRITE: if (last_wr && !io_hold) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            gmask <= '0;
            base  <= '0;
            size  <= '0;
            wdata <= '0;
            rbuf  <= '0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        cnt   <= '0;
                        gmask <= arb_onehot;
                        base  <= sel_addr;
                        size  <= sel_size;
                        wdata <= sel_wdata;
                    end
                end
                ST_READ: begin
                    if (aborted || last_rd) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                        case (cnt)
                            3'd1:    rbuf[7:0]   <= ram_data_i;
                            3'd2:    rbuf[15:8]  <= ram_data_i;
                            3'd3:    rbuf[23:16] <= ram_data_i;
                            default: ;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (!io_hold) begin
                        cnt <= last_wr ? 3'd0 : cnt + 3'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_wr_o   = 1'b0;
        done_o     = '0;
        rdata_o    = '0;
        busy_o     = (state != ST_IDLE);
        case (state)
            ST_READ: begin
                ram_addr_o = cur_addr;
                if (rdy && last_rd && !aborted) begin
                    done_o  = gmask;
                    rdata_o = rd_word;
                end
            end
            ST_WRITE: begin
                ram_addr_o = cur_addr;
                ram_data_o = wbyte;
                if (rdy && !io_hold) begin
                    ram_wr_o = 1'b1;
                    if (last_wr) done_o = gmask;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
// ============================================================================
// Module : tb_mem_port_ctrl
// Brief  : Directed, table-driven bench for mem_port_ctrl with a byte RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [7:0]  ram_data_i = 8'h00;
    logic [7:0]  ram_data_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic        io_full;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [3:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  abort;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic        busy_o;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    // RAM returns the byte for last cycle's address; it pauses along with rdy.
    always @(posedge clk) if (rdy) ram_data_i <= mem[ram_addr_o[7:0]];

    mem_port_ctrl #(.NCH(2), .AW(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .ram_data_i       (ram_data_i),
        .ram_data_o       (ram_data_o),
        .ram_addr_o       (ram_addr_o),
        .ram_wr_o         (ram_wr_o),
        .io_buffer_full_i (io_full),
        .req_valid_i      (req_valid),
        .req_wr_i         (req_wr),
        .req_size_i       (req_size),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .abort_i          (abort),
        .done_o           (done_o),
        .rdata_o          (rdata_o),
        .busy_o           (busy_o)
    );

    typedef struct {
        int          ch;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          k;
    } vec_t;

    vec_t       vecs [7];
    logic [1:0] exp_seq [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[ch]          = 1'b1;
        req_wr[ch]             = wr;
        req_size[2*ch +: 2]    = size;
        req_addr[32*ch +: 32]  = addr;
        req_wdata[32*ch +: 32] = wdata;
    endtask

    task automatic run_vec(input vec_t t);
        logic [1:0] exp_done;
        int         nc;
        exp_done = 2'b01 << t.ch;
        nc       = t.wr ? t.k : t.k + 1;
        req_valid = '0;
        set_req(t.ch, t.wr, t.size, t.addr, t.wdata);
        @(posedge clk);
        for (int j = 1; j <= nc; j++) begin
            @(negedge clk);
            if (j <= t.k) begin
                chk("vec_addr", ram_addr_o, t.addr + 32'(j - 1));
                chk("vec_wr", {31'd0, ram_wr_o}, {31'd0, t.wr});
                if (t.wr) chk("vec_wbyte", {24'd0, ram_data_o}, (t.wdata >> (8 * (j - 1))) & 32'hFF);
            end
            chk("vec_done", {30'd0, done_o}, (j == nc) ? {30'd0, exp_done} : 32'd0);
            if (j == nc && !t.wr) chk("vec_rdata", rdata_o, t.exp_rdata);
        end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("vec_idle", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

        //          ch wr    size  addr           wdata          exp_rdata      k
        vecs[0] = '{0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h4433_2211, 4};
        vecs[1] = '{1, 1'b0, 2'd0, 32'h0000_0042, 32'h0,         32'h0000_0052, 1};
        vecs[2] = '{0, 1'b0, 2'd1, 32'h0000_01FF, 32'h0,         32'h0000_110F, 2};
        vecs[3] = '{1, 1'b1, 2'd1, 32'h0002_FFFF, 32'h0000_BEEF, 32'h0,         2};
        vecs[4] = '{0, 1'b1, 2'd3, 32'h0000_1000, 32'hCAFE_F00D, 32'h0,         4};
        vecs[5] = '{1, 1'b1, 2'd0, 32'h0000_0000, 32'h1234_5678, 32'h0,         1};
        vecs[6] = '{0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'h2211_0F0E, 4};

`ifdef MEMCTRL_ROUND_ROBIN_EN
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        rst = 1'b0; rdy = 1'b1; io_full = 1'b0; abort = '0;
        req_valid = 2'b11; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;

        // Reset with both channels requesting: nothing may be granted.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_done", {30'd0, done_o}, 32'd0);
            chk("rst_wr", {31'd0, ram_wr_o}, 32'd0);
            chk("rst_busy", {31'd0, busy_o}, 32'd0);
            chk("rst_addr", ram_addr_o, 32'd0);
        end
        rst = 1'b1; req_valid = '0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        // IO byte write held three cycles by a full UART buffer.
        io_full = 1'b1;
        set_req(0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("io_hold_wr", {31'd0, ram_wr_o}, 32'd0);
            chk("io_hold_addr", ram_addr_o, 32'h0003_0000);
            chk("io_hold_done", {30'd0, done_o}, 32'd0);
            @(posedge clk);
        end
        #1 io_full = 1'b0;
        @(negedge clk);
        chk("io_wr", {31'd0, ram_wr_o}, 32'd1);
        chk("io_byte", {24'd0, ram_data_o}, 32'h5A);
        chk("io_done", {30'd0, done_o}, 32'd1);
        @(posedge clk);
        #1 req_valid = '0;

        // Word read on ch0 aborted in its second cycle.
        set_req(0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_addr0", ram_addr_o, 32'h0000_0100);
        @(posedge clk);
        #1 abort = 2'b01;
        @(negedge clk);
        chk("abort_done", {30'd0, done_o}, 32'd0);
        @(posedge clk);
        #1 begin abort = '0; req_valid = '0; end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_idle", {31'd0, busy_o}, 32'd0);
            chk("abort_nodone", {30'd0, done_o}, 32'd0);
        end

        // Word read on ch1 with rdy low for two cycles after the second byte.
        set_req(1, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rdy_addr0", ram_addr_o, 32'h0000_0100);
        @(negedge clk);
        chk("rdy_addr1", ram_addr_o, 32'h0000_0101);
        @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rdy_hold_addr", ram_addr_o, 32'h0000_0102);
            chk("rdy_hold_wr", {31'd0, ram_wr_o}, 32'd0);
            chk("rdy_hold_done", {30'd0, done_o}, 32'd0);
        end
        @(posedge clk);
        #1 rdy = 1'b1;
        @(negedge clk);
        chk("rdy_addr2", ram_addr_o, 32'h0000_0102);
        chk("rdy_done_early", {30'd0, done_o}, 32'd0);
        @(negedge clk);
        chk("rdy_addr3", ram_addr_o, 32'h0000_0103);
        chk("rdy_done_early", {30'd0, done_o}, 32'd0);
        @(negedge clk);
        chk("rdy_done", {30'd0, done_o}, 32'd2);
        chk("rdy_rdata", rdata_o, 32'h4433_2211);
        @(posedge clk);
        #1 req_valid = '0;

        // Both channels requesting back to back.
        set_req(0, 1'b0, 2'd0, 32'h0000_0010, 32'h0);
        set_req(1, 1'b0, 2'd0, 32'h0000_0020, 32'h0);
        for (int n = 0; n < 4; n++) begin
            waited = 0;
            @(negedge clk);
            while (done_o == 2'b00 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("arb_grant", {30'd0, done_o}, {30'd0, exp_seq[n]});
            chk("arb_rdata", rdata_o, exp_seq[n][1] ? 32'h30 : 32'h20);
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
